// File: rtl/io_pkg.sv
// Shared types and constants for the I/O register arbiter.
// Holds register address map, arbiter FSM states and the latched command.
// No logic beyond the address-validity helper.
package io_pkg;

  // I/O register address map; anything above DDRB has no backing register.
  localparam logic [2:0] PORTA = 3'd0;
  localparam logic [2:0] DDRA  = 3'd1;
  localparam logic [2:0] PORTB = 3'd2;
  localparam logic [2:0] DDRB  = 3'd3;

  // Returned on a read that produced no data.
  localparam logic [7:0] RD_ERR_DATA = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef struct packed {
    logic       we;
    logic [2:0] addr;
    logic [7:0] data;
  } io_cmd_t;

  function automatic logic addr_valid(input logic [2:0] addr);
    return addr <= DDRB;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbitration decision, purely combinational.
// Latency: 0 cycles. Backpressure: none, callers sample grant when they can accept it.
// Ports: req[1:0] requests, ptr (0 = requester 0 wins a tie, 1 = requester 1),
//        fixed (1 = requester 0 always wins), grant[1:0] one-hot or zero.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       fixed,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (fixed) begin
      if (req[0])      grant = 2'b01;
      else if (req[1]) grant = 2'b10;
    end else begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/io_arb.sv
// Arbitrates two requesters onto one I/O register port, one transaction at a time.
// Latency: IDLE (grant) -> ISSUE (io_enable) -> RESP (ack), exactly 3 cycles per transaction.
// Backpressure: requesters hold req until their ack; requests are only sampled in IDLE.
// Ports: clk/rst (sync, active-high); req/we/addr/wdata per requester in, ack/rdata per
//        requester out, err with a failed read's ack; io_* command out, io_DO/io_OE read return.
module io_arb
  import io_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [2:0] addr0,
  input  logic [2:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rdata0,
  output logic [7:0] rdata1,
  output logic       err,
  output logic       io_enable,
  output logic       io_we_n,
  output logic [2:0] io_A,
  output logic [7:0] io_DI,
  input  logic [7:0] io_DO,
  input  logic       io_OE
);

  state_t     state, state_nxt;
  io_cmd_t    cmd, cmd_nxt;
  logic       gnt_1;     // owner of the transaction in flight: 1 = requester 1
  logic       ptr;       // tie-break: 0 favours requester 0
  logic [1:0] grant;
  logic [7:0] rsp_data;
  logic       rsp_err;

  rr_arb2 u_rr_arb2 (
    .req   ({req1, req0}),
    .ptr   (ptr),
    .fixed (FIXED_PRIO),
    .grant (grant)
  );

  always_comb begin
    if (grant[1]) begin
      cmd_nxt.we   = we1;
      cmd_nxt.addr = addr1;
      cmd_nxt.data = wdata1;
    end else begin
      cmd_nxt.we   = we0;
      cmd_nxt.addr = addr0;
      cmd_nxt.data = wdata0;
    end
  end

  // Requester inputs are captured only on the IDLE grant, so anything they do
  // during ISSUE/RESP cannot disturb the transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ptr   <= 1'b0;
      cmd   <= '0;
      gnt_1 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && grant != 2'b00) begin
        cmd   <= cmd_nxt;
        gnt_1 <= grant[1];
        ptr   <= ~grant[1];
      end
    end
  end

  // Out-of-map reads never trust io_OE; they always complete as failed reads.
  always_comb begin
    rsp_data = '0;
    rsp_err  = 1'b0;
    if (!cmd.we) begin
      if (addr_valid(cmd.addr) && io_OE) begin
        rsp_data = io_DO;
      end else begin
        rsp_data = RD_ERR_DATA;
        rsp_err  = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ack0      = 1'b0;
    ack1      = 1'b0;
    rdata0    = '0;
    rdata1    = '0;
    err       = 1'b0;
    io_enable = 1'b0;
    io_we_n   = 1'b1;
    io_A      = '0;
    io_DI     = '0;
    case (state)
      ST_IDLE: begin
        if (grant != 2'b00) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_nxt = ST_RESP;
        io_enable = 1'b1;
        io_we_n   = ~cmd.we;
        io_A      = cmd.addr;
        io_DI     = cmd.we ? cmd.data : 8'h00;
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
        err       = rsp_err;
        if (gnt_1) begin
          ack1   = 1'b1;
          rdata1 = rsp_data;
        end else begin
          ack0   = 1'b1;
          rdata0 = rsp_data;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Reset masks outputs in the same cycle so an aborted transaction never acks.
    if (rst) begin
      state_nxt = ST_IDLE;
      ack0      = 1'b0;
      ack1      = 1'b0;
      rdata0    = '0;
      rdata1    = '0;
      err       = 1'b0;
      io_enable = 1'b0;
      io_we_n   = 1'b1;
      io_A      = '0;
      io_DI     = '0;
    end
  end

endmodule

// File: doc/io_arb.md
IO_ARB -- requirements
Module: io_arb

Interface
REQ-001 SHALL have parameter FIXED_PRIO, default 0; 0 = round-robin between requesters, 1 = requester 0 always wins.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports req0/req1  input  1 each  access request; held until acknowledged.
REQ-005 SHALL have ports we0/we1  input  1 each  1 = write, 0 = read.
REQ-006 SHALL have ports addr0/addr1  input  3 each  register address (0 PORTA, 1 DDRA, 2 PORTB, 3 DDRB).
REQ-007 SHALL have ports wdata0/wdata1  input  8 each  write data.
REQ-008 SHALL have ports ack0/ack1  output  1 each  one-cycle completion pulse.
REQ-009 SHALL have ports rdata0/rdata1  output  8 each  read data, valid only in the cycle its ack is high.
REQ-010 SHALL have port err  output  1  one-cycle pulse alongside an ack for a read that returned no data.
REQ-011 SHALL have ports io_enable  output  1; io_we_n  output  1; io_A  output  3; io_DI  output  8  -- the I/O register port command.
REQ-012 SHALL have ports io_DO  input  8; io_OE  input  1  -- I/O register read return, one cycle after io_enable.

Function
REQ-013 SHALL implement FSM IDLE -> ISSUE -> RESP -> IDLE; one transaction takes exactly 3 cycles.
REQ-014 In IDLE with any req high, SHALL pick a winner, latch its we/addr/wdata into a command register, record the grant, and go to ISSUE; with no req, SHALL stay in IDLE.
REQ-015 Round-robin: with both requesting, the requester not granted most recently SHALL win; with one requesting, it SHALL win regardless of the pointer.
REQ-016 The pointer SHALL update only on a grant.
REQ-017 In ISSUE, io_enable SHALL be 1 for exactly one cycle, with io_we_n = ~we, io_A = addr, io_DI = wdata (writes) or 0 (reads).
REQ-018 In all other states, io_enable SHALL be 0, io_we_n 1, io_A 0 and io_DI 0.
REQ-019 In RESP, the granted requester's ack SHALL be 1 for one cycle; the other ack SHALL stay 0.
REQ-020 Read responses: rdata = io_DO if io_OE = 1, else 8'hFF with err = 1.
REQ-021 Write responses: rdata = 0 and err = 0.
REQ-022 The non-granted rdata SHALL be 0.
REQ-023 Addresses 4-7 SHALL be forwarded unchanged: writes complete silently; reads complete with 8'hFF and err = 1.
REQ-024 Requests seen in ISSUE or RESP SHALL wait and be arbitrated in the next IDLE.
REQ-025 A req still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-026 Requester inputs SHALL be sampled only in IDLE; changes during ISSUE/RESP SHALL NOT affect the transaction in flight.
REQ-027 Each transaction SHALL produce exactly one ack, never two acks in the same cycle.

Reset
REQ-028 While rst = 1, SHALL force state IDLE, round-robin pointer favouring requester 0, and clear the command register.
REQ-029 While rst = 1, SHALL drive ack0 = ack1 = 0, rdata0 = rdata1 = 0, err = 0, io_enable = 0, io_we_n = 1, io_A = 0, io_DI = 0.
REQ-030 Reset asserted in ISSUE or RESP SHALL abort the transaction: no ack issued, and a write already issued is not retracted.

Structure
REQ-031 Package io_pkg SHALL hold the register address constants (PORTA, DDRA, PORTB, DDRB), the FSM state enum, and the io_cmd_t struct {we, addr[2:0], data[7:0]}.
REQ-032 Sub-module rr_arb2 SHALL hold the pure 2-way round-robin decision: inputs req[1:0], ptr, fixed; output grant[1:0], one-hot or zero.

Verification
REQ-033 Single write: req0 with we0=1, addr0=0, wdata0=8'hA5 -> io_enable high one cycle with io_we_n=0, io_A=0, io_DI=8'hA5; ack0 the next cycle; rdata0=0.
REQ-034 Read return: req1 read addr1=1 while io model returns io_DO=8'h3C, io_OE=1 -> ack1 3 cycles after the request with rdata1=8'h3C and err=0.
REQ-035 Contention, FIXED_PRIO=0: req0 and req1 both held from reset -> grants alternate 0,1,0,1, one ack every 3 cycles; with FIXED_PRIO=1 -> only requester 0 is served while req0 stays high.
REQ-036 Invalid read: read addr0=5 with io_OE=0 -> ack0 with rdata0=8'hFF and err=1.
REQ-037 Reset mid-transaction: rst asserted in ISSUE -> no ack; all outputs at reset values the next cycle; the first post-reset contention grant goes to requester 0.
REQ-038 Input stability: change wdata0 during ISSUE -> io_DI keeps the value latched in IDLE.
